// File: rtl/conv1d_stream_engine_if.sv
// rtl/conv1d_stream_engine_if.sv - result stream and weight-load bus for conv1d_stream_engine
interface conv1d_stream_engine_if #(
    parameter int OUT_W  = 18,
    parameter int IDX_W  = 5,
    parameter int WGT_W  = 8,
    parameter int WIDX_W = 2
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    wgt_we;
    logic [WIDX_W-1:0]       wgt_idx;
    logic signed [WGT_W-1:0] wgt_data;

    modport master (
        output out_valid, out_data, out_idx, out_last,
        input  out_ready, wgt_we, wgt_idx, wgt_data
    );
    modport slave (
        input  out_valid, out_data, out_idx, out_last,
        output out_ready, wgt_we, wgt_idx, wgt_data
    );
endinterface

// File: rtl/conv1d_stream_engine.sv
// rtl/conv1d_stream_engine.sv - K-tap signed 1-D convolution over one latched pixel row, streamed out
module conv1d_stream_engine #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int N_PIX  = 32,
    parameter int K      = 3,
    parameter int OUT_W  = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_PIX*DATA_W-1:0]   pixel_row_data,
    input  logic                      pad_en,
    input  logic                      relu_en,
    output logic                      busy,
    output logic                      done,
    conv1d_stream_engine_if.master    bus
);
    localparam int IDX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int WIDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int P      = (K - 1) / 2;
    localparam int PROD_W = DATA_W + WGT_W;
    localparam int ACC_W  = PROD_W + $clog2(K) + 1;
    localparam int CW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_SAME  = IDX_W'(N_PIX - 1);
    localparam logic [IDX_W-1:0] LAST_VALID = IDX_W'(N_PIX - K);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   row_q    [N_PIX];
    logic signed [WGT_W-1:0]    w_shadow [K];
    logic signed [WGT_W-1:0]    w_work   [K];
    logic                       pad_q, relu_q;
    logic [IDX_W-1:0]           j_q;
    logic                       accept, run, last_hit;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [CW-1:0]       acc_x, res;
    logic signed [OUT_W-1:0]    result;
    int                         pos;

    assign accept   = (state_q == S_IDLE) && start;
    assign run      = (state_q == S_RUN);
    assign last_hit = (j_q == (pad_q ? LAST_SAME : LAST_VALID));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (bus.out_ready && last_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_idx   = '0;
        bus.out_data  = '0;
        case (state_q)
            S_RUN: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = last_hit;
                bus.out_idx   = j_q;
                bus.out_data  = result;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // A weight write coinciding with an accepted start lands in the working bank too.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PIX; i++) row_q[i] <= '0;
            for (int t = 0; t < K; t++) begin
                w_shadow[t] <= '0;
                w_work[t]   <= '0;
            end
            pad_q  <= 1'b0;
            relu_q <= 1'b0;
            j_q    <= '0;
        end else begin
            for (int t = 0; t < K; t++)
                if (bus.wgt_we && bus.wgt_idx == WIDX_W'(t)) w_shadow[t] <= bus.wgt_data;
            if (accept) begin
                for (int i = 0; i < N_PIX; i++) row_q[i] <= pixel_row_data[i*DATA_W +: DATA_W];
                for (int t = 0; t < K; t++)
                    w_work[t] <= (bus.wgt_we && bus.wgt_idx == WIDX_W'(t)) ? bus.wgt_data : w_shadow[t];
                pad_q  <= pad_en;
                relu_q <= relu_en;
                j_q    <= '0;
            end else if (run && bus.out_ready && !last_hit) begin
                j_q <= j_q + IDX_W'(1);
            end
        end
    end

    // Taps falling outside the row contribute zero, which implements same-mode padding.
    always_comb begin
        acc  = '0;
        pos  = 0;
        prod = '0;
        for (int t = 0; t < K; t++) begin
            pos  = int'(j_q) + t - (pad_q ? P : 0);
            prod = '0;
            if (pos >= 0 && pos < N_PIX)
                prod = PROD_W'(row_q[pos[IDX_W-1:0]]) * PROD_W'(w_work[t]);
            acc = acc + ACC_W'(prod);
        end
        acc_x = CW'(acc);
        if (acc_x > SAT_MAX)      res = SAT_MAX;
        else if (acc_x < SAT_MIN) res = SAT_MIN;
        else                      res = acc_x;
        if (relu_q && res < 0) res = '0;
        result = OUT_W'(res);
    end
endmodule

// File: tb/tb_conv1d_stream_engine.sv
// tb/tb_conv1d_stream_engine.sv - scoreboard bench for conv1d_stream_engine at 18-bit and 12-bit result widths
module tb_conv1d_stream_engine;
    localparam int N = 32;

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         pad_en = 1'b0;
    logic         relu_en = 1'b0;
    logic [N*8-1:0] row = '0;
    logic         busy0, busy1, done0, done1;

    int   checks = 0;
    int   failures = 0;
    int   x [N];
    int   w_sh [3];
    exp_t q [2][$];
    bit   pend [2];

    logic m_v, m_r, m_l, m_dn;
    int   m_d, m_i;
    exp_t m_e;

    conv1d_stream_engine_if #(.OUT_W(18), .IDX_W(5), .WGT_W(8), .WIDX_W(2)) bus0 ();
    conv1d_stream_engine_if #(.OUT_W(12), .IDX_W(5), .WGT_W(8), .WIDX_W(2)) bus1 ();

    assign bus1.out_ready = bus0.out_ready;
    assign bus1.wgt_we    = bus0.wgt_we;
    assign bus1.wgt_idx   = bus0.wgt_idx;
    assign bus1.wgt_data  = bus0.wgt_data;

    conv1d_stream_engine #(.DATA_W(8), .WGT_W(8), .N_PIX(N), .K(3), .OUT_W(18)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pixel_row_data(row),
        .pad_en(pad_en), .relu_en(relu_en), .busy(busy0), .done(done0), .bus(bus0.master)
    );
    conv1d_stream_engine #(.DATA_W(8), .WGT_W(8), .N_PIX(N), .K(3), .OUT_W(12)) dut1 (
        .clk(clk), .rst(rst), .start(start), .pixel_row_data(row),
        .pad_en(pad_en), .relu_en(relu_en), .busy(busy1), .done(done1), .bus(bus1.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(int j, bit pad, bit relu, int ow);
        int acc = 0;
        int p;
        int lim = 1 << (ow - 1);
        for (int t = 0; t < 3; t++) begin
            p = j + t - (pad ? 1 : 0);
            if (p >= 0 && p < N) acc += w_sh[t] * x[p];
        end
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim) acc = -lim;
        if (relu && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic set_w(input int idx, input int val);
        bus0.wgt_we   = 1'b1;
        bus0.wgt_idx  = 2'(idx);
        bus0.wgt_data = 8'(val);
        w_sh[idx] = val;
        tick();
        bus0.wgt_we = 1'b0;
    endtask

    task automatic start_row(input bit pad, input bit relu, input bit we, input int widx, input int wval);
        int m = pad ? N : N - 2;
        exp_t e;
        if (we) w_sh[widx] = wval;
        for (int i = 0; i < N; i++) row[i*8 +: 8] = 8'(x[i]);
        pad_en        = pad;
        relu_en       = relu;
        start         = 1'b1;
        bus0.wgt_we   = we;
        bus0.wgt_idx  = 2'(widx);
        bus0.wgt_data = 8'(wval);
        for (int j = 0; j < m; j++)
            for (int k = 0; k < 2; k++) begin
                e.data = model(j, pad, relu, (k == 1) ? 12 : 18);
                e.idx  = j;
                e.last = (j == m - 1);
                q[k].push_back(e);
            end
        tick();
        start       = 1'b0;
        bus0.wgt_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = done0;
        end
        chk({name, "_done0"}, int'(seen), 1);
        chk({name, "_done1"}, int'(done1), 1);
        chk({name, "_drained"}, q[0].size() + q[1].size(), 0);
        tick();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_v  = (k == 1) ? bus1.out_valid : bus0.out_valid;
                    m_r  = (k == 1) ? bus1.out_ready : bus0.out_ready;
                    m_l  = (k == 1) ? bus1.out_last  : bus0.out_last;
                    m_dn = (k == 1) ? done1 : done0;
                    m_d  = (k == 1) ? int'(bus1.out_data) : int'(bus0.out_data);
                    m_i  = (k == 1) ? int'(bus1.out_idx)  : int'(bus0.out_idx);
                    if (m_dn || pend[k])
                        chk($sformatf("done_pulse%0d", k), int'(m_dn), int'(pend[k]));
                    if (m_v && m_r) begin
                        if (q[k].size() == 0) begin
                            chk($sformatf("unexpected_out%0d_idx%0d", k, m_i), 1, 0);
                        end else begin
                            m_e = q[k].pop_front();
                            chk($sformatf("out%0d_data_j%0d", k, m_e.idx), m_d, m_e.data);
                            chk($sformatf("out%0d_idx", k), m_i, m_e.idx);
                            chk($sformatf("out%0d_last_j%0d", k, m_e.idx), int'(m_l), int'(m_e.last));
                        end
                    end
                    pend[k] = m_v && m_r && m_l;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  stalls, snap;
        bit  wrote, fin;
        bus0.out_ready = 1'b1;
        bus0.wgt_we    = 1'b0;
        bus0.wgt_idx   = '0;
        bus0.wgt_data  = '0;
        for (int i = 0; i < N; i++) x[i] = 0;
        for (int t = 0; t < 3; t++) w_sh[t] = 0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_valid0", int'(bus0.out_valid), 0);
        chk("rst_valid1", int'(bus1.out_valid), 0);
        chk("rst_last0", int'(bus0.out_last), 0);
        chk("rst_data0", int'(bus0.out_data), 0);
        chk("rst_idx0", int'(bus0.out_idx), 0);
        tick();
        rst = 1'b0;

        set_w(0, -1);
        set_w(1, 2);
        set_w(2, -1);

        x[5] = 10;
        start_row(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done("valid");

        x[5] = 0;
        x[0] = 10;
        start_row(1'b1, 1'b0, 1'b0, 0, 0);
        wait_done("same");

        x[0] = 0;
        x[5] = 10;
        start_row(1'b0, 1'b1, 1'b0, 0, 0);
        wait_done("relu");

        // Backpressure at idx 2, ignored start mid-row, and a tap-1 write during the row.
        x[3] = 7;
        start_row(1'b0, 1'b0, 1'b0, 0, 0);
        stalls = 0;
        snap   = 0;
        wrote  = 1'b0;
        fin    = 1'b0;
        for (int c = 0; c < 150 && !fin; c++) begin
            start       = 1'b0;
            bus0.wgt_we = 1'b0;
            if (done0) begin
                fin = 1'b1;
            end else begin
                if (bus0.out_valid && bus0.out_idx == 5'd2 && stalls < 5) begin
                    if (stalls == 0) snap = int'(bus0.out_data);
                    bus0.out_ready = 1'b0;
                    stalls++;
                    if (stalls == 3) begin
                        start  = 1'b1;
                        pad_en = 1'b1;
                        row    = '1;
                    end
                    @(negedge clk);
                    chk("hold_data", int'(bus0.out_data), snap);
                    chk("hold_idx", int'(bus0.out_idx), 2);
                    chk("hold_valid", int'(bus0.out_valid), 1);
                end else begin
                    bus0.out_ready = 1'b1;
                    if (bus0.out_idx == 5'd15 && !wrote) begin
                        bus0.wgt_we   = 1'b1;
                        bus0.wgt_idx  = 2'd1;
                        bus0.wgt_data = 8'sd5;
                        w_sh[1] = 5;
                        wrote   = 1'b1;
                    end
                end
                tick();
            end
        end
        start          = 1'b0;
        bus0.wgt_we    = 1'b0;
        bus0.out_ready = 1'b1;
        chk("bp_done", int'(fin), 1);
        chk("bp_stalls", stalls, 5);
        chk("bp_snap_value", snap, 14);
        chk("bp_drained", q[0].size() + q[1].size(), 0);
        tick();

        // Tap 1 = 5 from the mid-row write; tap 2 = 4 written together with start.
        start_row(1'b0, 1'b0, 1'b1, 2, 4);
        wait_done("newwgt");

        set_w(0, 127);
        set_w(1, 127);
        set_w(2, 127);
        for (int i = 0; i < N; i++) x[i] = -128;
        start_row(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done("sat_neg");
        for (int i = 0; i < N; i++) x[i] = 127;
        start_row(1'b1, 1'b0, 1'b0, 0, 0);
        wait_done("sat_pos");

        for (int i = 0; i < N; i++) x[i] = 0;
        x[5] = 10;
        set_w(0, -1);
        set_w(1, 2);
        set_w(2, -1);
        start_row(1'b0, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < 60 && !(bus0.out_valid && bus0.out_idx == 5'd10); c++) tick();
        chk("rst_reach_idx10", int'(bus0.out_idx), 10);
        rst = 1'b1;
        tick();
        chk("abort_valid0", int'(bus0.out_valid), 0);
        chk("abort_busy0", int'(busy0), 0);
        chk("abort_valid1", int'(bus1.out_valid), 0);
        chk("abort_busy1", int'(busy1), 0);
        rst = 1'b0;
        q[0].delete();
        q[1].delete();
        for (int t = 0; t < 3; t++) w_sh[t] = 0;
        repeat (3) tick();
        set_w(0, -1);
        set_w(1, 2);
        set_w(2, -1);
        start_row(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done("after_rst");

        repeat (3) tick();
        chk("final_drained", q[0].size() + q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
